// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between WB, the buffered jal link and the MDU.
// Write port is registered (grant in cycle n, write in n+1); WB never stalls, jal stalls via StallD, MDU via MduReady.
module regfile_write_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [4:0]  LINK_REG     = 5'd31
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        JalD,
    input  logic [31:0] PCnormalD,
    input  logic        MduValid,
    input  logic [4:0]  MduReg,
    input  logic [31:0] MduData,
    output logic        MduReady,
    output logic        RegWE,
    output logic [4:0]  RegWAddr,
    output logic [31:0] RegWData,
    output logic        StallD,
    output logic [31:0] PendingMask,
    output logic        MduStarved
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          link_valid;
    logic [31:0]   link_val;
    logic [1:0]    link_age;
    logic [SW-1:0] starve_cnt;

    logic wb_req;
    logic mdu_req;
    logic starve_at_limit;
    logic mdu_xfer;
    logic mdu_wr;
    logic link_grant;
    logic supersede;
    logic link_capture;

    assign wb_req          = RegWriteW & (WriteRegW != 5'd0);
    assign mdu_req         = MduValid & (MduReg != 5'd0);
    assign starve_at_limit = (starve_cnt == SW'(STARVE_LIMIT));

    // Gated by reset so no MDU handshake can complete while the block is held in reset.
    assign MduReady   = Reset_n & ~wb_req & (~link_valid | starve_at_limit);
    assign mdu_xfer   = MduValid & MduReady;
    assign mdu_wr     = mdu_xfer & mdu_req;

    // An MDU transfer to $0 writes nothing, so the link may still use the port that cycle.
    assign link_grant   = ~wb_req & link_valid & ~mdu_wr;
    assign supersede    = wb_req & (WriteRegW == LINK_REG) & link_valid & (link_age == 2'd3);
    assign StallD       = JalD & link_valid & ~link_grant;
    assign link_capture = JalD & ~StallD;
    assign MduStarved   = starve_at_limit;

    always_comb begin
        PendingMask = '0;
        if (link_valid)
            PendingMask[LINK_REG] = 1'b1;
        if (Reset_n & mdu_req & ~mdu_xfer)
            PendingMask[MduReg] = 1'b1;
        PendingMask[0] = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWE    <= 1'b0;
            RegWAddr <= 5'd0;
            RegWData <= 32'd0;
        end else begin
            RegWE <= wb_req | link_grant | mdu_wr;
            if (wb_req) begin
                RegWAddr <= WriteRegW;
                RegWData <= ResultW;
            end else if (mdu_wr) begin
                RegWAddr <= MduReg;
                RegWData <= MduData;
            end else if (link_grant) begin
                RegWAddr <= LINK_REG;
                RegWData <= link_val;
            end else begin
                RegWAddr <= 5'd0;
                RegWData <= 32'd0;
            end
        end
    end

    // A stale link is dropped when WB overwrites the same register; a young one still lands after it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            link_valid <= 1'b0;
            link_val   <= 32'd0;
            link_age   <= 2'd0;
        end else if (link_capture) begin
            link_valid <= 1'b1;
            link_val   <= PCnormalD;
            link_age   <= 2'd0;
        end else if (link_grant | supersede) begin
            link_valid <= 1'b0;
            link_age   <= 2'd0;
        end else if (link_valid && link_age != 2'd3) begin
            link_age   <= link_age + 2'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            starve_cnt <= '0;
        else if (mdu_xfer)
            starve_cnt <= '0;
        else if (MduValid & link_valid & ~wb_req & ~starve_at_limit)
            starve_cnt <= starve_cnt + SW'(1);
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single register-file write port in the 5-stage pipeline and shares it between three requesters.
- Requesters: WB-stage writeback, jal link write of PCnormalD to $31, and a multi-cycle multiply/divide unit (MDU) with a valid/ready handshake.
- Buffers the deferred link write and applies priority plus an anti-starvation rule.
- Exports a pending-write mask so the hazard unit can stall decode reads.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles of MDU blocked by the link buffer before the MDU outranks the link buffer.
- LINK_REG, 31, destination register of the link write.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- RegWriteW  in  1  WB write request.
- WriteRegW  in  5  WB destination.
- ResultW  in  32  WB data.
- JalD  in  1  link request, one-cycle pulse per jal.
- PCnormalD  in  32  link value (PC+4).
- MduValid  in  1  MDU result valid.
- MduReg  in  5  MDU destination.
- MduData  in  32  MDU result.
- MduReady  out  1  MDU result accepted this cycle.
- RegWE  out  1  write enable to the register file.
- RegWAddr  out  5  write address.
- RegWData  out  32  write data.
- StallD  out  1  decode must hold the jal; link buffer cannot accept.
- PendingMask  out  32  bit r set when a write to r is buffered or offered by the MDU.
- MduStarved  out  1  starvation counter saturated.

Behaviour:
- Reset (async, Reset_n=0): RegWE=0, RegWAddr=0, RegWData=0, link buffer invalid, LinkAge=0, starve counter=0.
  - Consequently MduReady=0, StallD=0, PendingMask=0, MduStarved=0.
  - A reset mid-transfer discards the buffered link; MDU data is dropped only if not yet handshaken.
- Request qualification:
  - wb_req = RegWriteW & (WriteRegW!=0).
  - mdu_req = MduValid & (MduReg!=0).
  - MduValid with MduReg=0 is still accepted (MduReady may rise) but produces no write.
- Write port outputs are registered: a grant in cycle n gives RegWE/RegWAddr/RegWData valid in cycle n+1, one write per cycle.
- Priority per cycle:
  - WB always wins; WB never stalls.
  - Otherwise the link buffer wins.
  - Otherwise the MDU wins.
  - Exception: when starve counter = STARVE_LIMIT, the MDU outranks the link buffer (never WB).
- Link buffer (1 entry, value and LinkAge):
  - On posedge with JalD=1 and the buffer free or draining this cycle, capture PCnormalD and set LinkAge=0.
  - LinkAge increments each cycle the entry is held, saturating at 3.
  - Drain and refill in the same cycle is allowed.
- StallD = JalD & LinkValid & ~link_grant (combinational).
  - While StallD=1 the jal is not captured and decode re-presents it.
- Supersede rule: WB write to LINK_REG while LinkValid and LinkAge>=3 clears the link entry (the younger writeback wins).
  - With LinkAge<3 the link entry is kept and written after the WB write, because it is younger.
- MduReady = ~wb_req & (~LinkValid | starve_at_limit) (combinational).
  - Transfer occurs on MduValid & MduReady; the MDU holds MduReg/MduData stable until then.
- Starve counter:
  - Increments on MduValid & ~MduReady & LinkValid & ~wb_req.
  - Saturates at STARVE_LIMIT and clears on MDU transfer.
  - MduStarved = (counter==STARVE_LIMIT).
  - Cycles blocked only by WB do not count.
- PendingMask:
  - Bit LINK_REG set when LinkValid.
  - Bit MduReg set when mdu_req and not transferring.
  - Bit 0 always 0.
- Same-cycle JalD, wb_req and mdu_req with the buffer empty: WB is written; the link is captured; the MDU waits (MduReady=0).

Test Plan:
- Release Reset_n; RegWriteW=1, WriteRegW=5, ResultW=0x12 -> next cycle RegWE=1, RegWAddr=5, RegWData=0x12; all other outputs 0.
- RegWriteW=1, WriteRegW=0 -> RegWE stays 0; a pending MDU (MduReg=8, MduData=0x77) is granted instead, giving RegWE=1, RegWAddr=8.
- JalD pulse with PCnormalD=0x40 while WB busy for 2 cycles -> PendingMask[31]=1 for 2 cycles; 3rd cycle write $31=0x40; PendingMask[31] cleared after the grant.
- Second JalD while the link is held and WB is busy -> StallD=1 for that cycle; the jal is captured in the cycle the link drains.
- Hold MduValid=1 (MduReg=9) with back-to-back jal links -> after 4 blocked cycles MduStarved=1, MduReady=1, $9 written before the next link; the counter returns to 0.
- Link held with LinkAge=3, then WB writes $31=0xAA -> the link entry is dropped; $31 ends at 0xAA. Repeat with LinkAge=1 -> $31 ends at the link value.
- Assert Reset_n=0 asynchronously mid-hold -> all outputs 0 immediately, without waiting for a Clock edge.
